lsu: RTL

Load/store unit between the decode/execute stage and the data-memory bus. It consumes the memory-control outputs of the main decoder: `mem_wen`, `mem_ren` and `mem_op`, together with the ALU-computed address and the rs2 data. It then performs one aligned word transaction on a valid/ready data bus, with byte strobes for stores and byte-lane extraction plus sign/zero extension for loads. The core is stalled until the access completes.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 58 +++++
 rtl/lsu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory op codes and FSM state encodings.
package lsu_pkg;

  localparam int unsigned MEM_OP_WIDTH    = 3;
  localparam int unsigned LSU_STATE_WIDTH = 2;

  typedef enum logic [MEM_OP_WIDTH-1:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_LBU = 3'd3,
    MEM_LHU = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [LSU_STATE_WIDTH-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper: misalign check, store lane formatting, load extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [MEM_OP_WIDTH-1:0] op,
  input  logic [1:0]              addr_lo,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic                    misaligned,
  output logic [3:0]              wstrb,
  output logic [DATA_WIDTH-1:0]   wdata_fmt,
  output logic [DATA_WIDTH-1:0]   rdata_ext
);

  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic [DATA_WIDTH-1:0] lane;

  // Access size is derived from the op so load and store encodings share one path.
  always_comb begin
    is_byte = (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_SB);
    is_half = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
    is_word = (op == MEM_LW) || (op == MEM_SW);
    misaligned = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
  end

  // Store strobes and lane-replicated write data.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_fmt = wdata;
    if (is_byte) begin
      wstrb     = 4'b0001 << addr_lo;
      wdata_fmt = {4{wdata[7:0]}};
    end else if (is_half) begin
      wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
      wdata_fmt = {2{wdata[15:0]}};
    end else if (is_word) begin
      wstrb     = 4'b1111;
    end
  end

  // Load lane select followed by sign or zero extension.
  always_comb begin
    lane = rdata >> {addr_lo, 3'b000};
    case (op)
      MEM_LB:  rdata_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      MEM_LBU: rdata_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      MEM_LH:  rdata_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      MEM_LHU: rdata_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      MEM_LW:  rdata_ext = rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned word transaction per request on a valid/ready bus.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_wen,
  input  logic                    mem_ren,
  input  logic [MEM_OP_WIDTH-1:0] mem_op,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    lsu_stall,
  output logic                    lsu_done,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    misalign_err,
  output logic                    bus_req_valid,
  input  logic                    bus_req_ready,
  output logic                    bus_req_wen,
  output logic [ADDR_WIDTH-1:0]   bus_req_addr,
  output logic [3:0]              bus_req_wstrb,
  output logic [DATA_WIDTH-1:0]   bus_req_wdata,
  input  logic                    bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   bus_rsp_rdata
);

  lsu_state_e              state_q;
  logic [MEM_OP_WIDTH-1:0] op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [3:0]              wstrb_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    valid_q;
  logic                    done_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   load_data_q;

  logic                    req;
  logic [MEM_OP_WIDTH-1:0] sel_op;
  logic [1:0]              sel_addr_lo;
  logic                    misaligned;
  logic [3:0]              fmt_wstrb;
  logic [DATA_WIDTH-1:0]   fmt_wdata;
  logic [DATA_WIDTH-1:0]   rdata_ext;

  // The aligner sees the live request in IDLE and the captured one while the access is open.
  always_comb begin
    req         = mem_wen | mem_ren;
    sel_op      = (state_q == IDLE) ? mem_op : op_q;
    sel_addr_lo = (state_q == IDLE) ? mem_addr[1:0] : addr_q[1:0];
  end

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .op         (sel_op),
    .addr_lo    (sel_addr_lo),
    .wdata      (mem_wdata),
    .rdata      (bus_rsp_rdata),
    .misaligned (misaligned),
    .wstrb      (fmt_wstrb),
    .wdata_fmt  (fmt_wdata),
    .rdata_ext  (rdata_ext)
  );

  // Access FSM with registered bus fields and completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            op_q    <= mem_op;
            addr_q  <= mem_addr;
            wen_q   <= mem_wen;
            wstrb_q <= mem_wen ? fmt_wstrb : 4'b0000;
            wdata_q <= mem_wen ? fmt_wdata : '0;
            if (misaligned) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              if (!mem_wen) begin
                load_data_q <= '0;
              end
            end else begin
              state_q <= REQ;
              valid_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            valid_q <= 1'b0;
            if (wen_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RSP;
            end
          end
        end
        RSP: begin
          if (bus_rsp_valid) begin
            load_data_q <= rdata_ext;
            state_q     <= DONE;
            done_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall drops in DONE so the pipeline advances in the completion cycle.
  always_comb begin
    lsu_stall     = req && (state_q != DONE);
    lsu_done      = done_q;
    misalign_err  = err_q;
    load_data     = load_data_q;
    bus_req_valid = valid_q;
    bus_req_wen   = wen_q;
    bus_req_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    bus_req_wstrb = wstrb_q;
    bus_req_wdata = wdata_q;
  end

endmodule
